mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RESP_TIMEOUT, default 64: cycles waited in WAIT_RESP for a memory response before an error response; legal range 2..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_f_valid  input  1  fetch read request valid.
REQ-005 i_f_addr  input  `ADDRESS_WIDTH  fetch read address.
REQ-006 o_f_ready  output  1  fetch request accepted when i_f_valid && o_f_ready.
REQ-007 o_f_res_valid / o_f_data / o_f_err  output  1 / `DATA_WIDTH / 1  fetch response, data, timeout error.
REQ-008 i_f_res_ready  input  1  fetch consumes response.
REQ-009 i_l_valid / i_l_addr / i_l_cmd / i_l_data  input  1 / `ADDRESS_WIDTH / `MEM_CMD_WIDTH / `DATA_WIDTH  load-store request.
REQ-010 o_l_ready  output  1  load-store request accepted when i_l_valid && o_l_ready.
REQ-011 o_l_res_valid / o_l_data / o_l_err  output  1 / `DATA_WIDTH / 1  load-store response, data, timeout error.
REQ-012 i_l_res_ready  input  1  load-store consumes response.
REQ-013 o_m_valid / o_m_addr / o_m_cmd / o_m_data  output  1 / `ADDRESS_WIDTH / `MEM_CMD_WIDTH / `DATA_WIDTH  request to memory.
REQ-014 i_m_ready  input  1  memory accepts request when o_m_valid && i_m_ready.
REQ-015 i_m_res_valid / i_m_data  input  1 / `DATA_WIDTH  memory response; o_m_res_ready  output  1  response consumed.
REQ-016 o_timeout  output  1  sticky: a timeout has occurred since reset.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT_RESP, ERR_RESP; exactly one transaction outstanding at any time.
REQ-018 IDLE: o_f_ready/o_l_ready high only for the granted port, and only if its valid is high; all other states: both low.
REQ-019 Accepted request (addr, cmd, data, owner) registered at acceptance; fetch cmd forced to `MEM_CMD_READ, data to 0; next state ISSUE.
REQ-020 ISSUE: o_m_valid=1 with registered fields, held stable until i_m_ready; on handshake -> WAIT_RESP, timeout counter cleared.
REQ-021 WAIT_RESP: i_m_res_valid/i_m_data routed combinationally to owner's res_valid/data; o_m_res_ready = owner's res_ready; non-owner res_valid=0.
REQ-022 Response handshake (i_m_res_valid && owner res_ready) -> IDLE; a new request is acceptable the following cycle (min 3 cycles/transaction).
REQ-023 Every memory command, read or write, returns exactly one response; write responses forward memory data unchanged.
REQ-024 Counter increments each WAIT_RESP cycle without i_m_res_valid; on reaching RESP_TIMEOUT -> ERR_RESP, o_timeout set.
REQ-025 ERR_RESP: owner res_valid=1, data=0, err=1, o_m_res_ready=1 (discard); on owner res_ready -> IDLE.
REQ-026 Response arriving in the same cycle the counter reaches RESP_TIMEOUT wins; no timeout.
REQ-027 Responses arriving in IDLE or ISSUE are not consumed (o_m_res_ready=0); post-timeout late responses are a system error flagged by o_timeout.
REQ-028 Requester dropping valid before acceptance: no effect; requests not retracted after acceptance.

Reset
REQ-029 reset low: state IDLE, all output valids/readys/err 0, o_m_* fields 0, counter 0, o_timeout 0, last-grant = fetch; takes effect immediately, mid-transaction included; in-flight transaction abandoned.

Configuration
REQ-030 MEM_ARB_RR_EN defined: round-robin grant; on tie, grant the port not granted last; last-grant updates on every acceptance.
REQ-031 MEM_ARB_RR_EN undefined: fixed priority, load-store wins every tie; last-grant register absent.
REQ-032 Single requester valid: granted in either configuration.

Structure
REQ-033 `MEM_CMD_WIDTH, `MEM_CMD_READ/WRITE, `ADDRESS_WIDTH, `DATA_WIDTH, owner and FSM state encodings live in header.v.
REQ-034 Grant selection in sub-module mem_arb_pick (two valids + last-grant in, one-hot grant out); FSM, counter and routing in mem_arbiter.

Verification
REQ-035 Fetch read 0x100, memory ready same cycle, response 0xDEADBEEF 2 cycles later -> o_f_data=0xDEADBEEF, o_l_res_valid stays 0, IDLE after handshake.
REQ-036 Both valid in same cycle, RR on -> LSU first, then fetch; RR off, both held valid 4 transactions -> LSU granted all 4.
REQ-037 LSU write 0x200/0x55, i_m_ready low 5 cycles -> o_m_valid held, o_m_addr=0x200, o_m_data=0x55 stable throughout.
REQ-038 RESP_TIMEOUT=4, no memory response -> after 4 WAIT_RESP cycles o_l_res_valid=1, o_l_err=1, o_l_data=0, o_timeout=1 until reset.
REQ-039 reset asserted during WAIT_RESP -> all outputs 0 same cycle; after release fetch request accepted normally.
REQ-040 i_f_res_ready low 3 cycles with i_m_res_valid high -> o_m_res_ready low, state holds, response delivered on ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths, memory command codes, owner and FSM state
//               encodings for the memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_CMD_WIDTH
`define MEM_CMD_WIDTH 2
`endif
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 2'd0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 2'd1
`endif

package mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_ERR_RESP  = 2'd3
  } state_t;

  // Which requester owns the outstanding transaction
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LSU   = 1'b1
  } owner_t;

  // Timeout counter width; covers RESP_TIMEOUT up to 255
  localparam int unsigned CNT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Grant selection between fetch and load-store requesters.
//               One-hot grant: bit 0 = fetch, bit 1 = load-store.
//               MEM_ARB_RR_EN defined  : round-robin on ties.
//               MEM_ARB_RR_EN undefined: load-store wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_f_valid,
  input  logic       i_l_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_t     i_last_grant,
`endif
  output logic [1:0] o_grant
);

  // Pick one requester; a lone valid requester is always granted
  always_comb begin
    o_grant = 2'b00;
    if (i_f_valid && i_l_valid) begin
`ifdef MEM_ARB_RR_EN
      o_grant = (i_last_grant == OWNER_LSU) ? 2'b01 : 2'b10;
`else
      o_grant = 2'b10;
`endif
    end else if (i_l_valid) begin
      o_grant = 2'b10;
    end else if (i_f_valid) begin
      o_grant = 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch / load-store) memory arbiter with a single
//               outstanding transaction, response routing and a response
//               timeout that returns an error response to the owner.
//               Build option MEM_ARB_RR_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_f_valid,
  input  logic [`ADDRESS_WIDTH-1:0] i_f_addr,
  output logic                      o_f_ready,
  output logic                      o_f_res_valid,
  output logic [`DATA_WIDTH-1:0]    o_f_data,
  output logic                      o_f_err,
  input  logic                      i_f_res_ready,
  input  logic                      i_l_valid,
  input  logic [`ADDRESS_WIDTH-1:0] i_l_addr,
  input  logic [`MEM_CMD_WIDTH-1:0] i_l_cmd,
  input  logic [`DATA_WIDTH-1:0]    i_l_data,
  output logic                      o_l_ready,
  output logic                      o_l_res_valid,
  output logic [`DATA_WIDTH-1:0]    o_l_data,
  output logic                      o_l_err,
  input  logic                      i_l_res_ready,
  output logic                      o_m_valid,
  output logic [`ADDRESS_WIDTH-1:0] o_m_addr,
  output logic [`MEM_CMD_WIDTH-1:0] o_m_cmd,
  output logic [`DATA_WIDTH-1:0]    o_m_data,
  input  logic                      i_m_ready,
  input  logic                      i_m_res_valid,
  input  logic [`DATA_WIDTH-1:0]    i_m_data,
  output logic                      o_m_res_ready,
  output logic                      o_timeout
);

  localparam logic [CNT_WIDTH-1:0] c_resp_timeout = CNT_WIDTH'(RESP_TIMEOUT);

  state_t                      r_state;
  owner_t                      r_owner;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        r_timeout;
  logic [`ADDRESS_WIDTH-1:0]   r_m_addr;
  logic [`MEM_CMD_WIDTH-1:0]   r_m_cmd;
  logic [`DATA_WIDTH-1:0]      r_m_data;
`ifdef MEM_ARB_RR_EN
  owner_t                      r_last_grant;
`endif

  logic [1:0]                  w_grant;
  logic                        w_idle;
  logic                        w_wait;
  logic                        w_err;
  logic                        w_accept_f;
  logic                        w_accept_l;
  logic                        w_owner_res_ready;
  logic                        w_res_valid;
  logic [`DATA_WIDTH-1:0]      w_res_data;
  logic [CNT_WIDTH-1:0]        w_cnt_next;

  mem_arb_pick u_pick (
    .i_f_valid    (i_f_valid),
    .i_l_valid    (i_l_valid),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_grant      (w_grant)
  );

  // Readies are gated by reset so nothing is accepted while it is held
  assign w_idle     = (r_state == ST_IDLE) && reset;
  assign w_wait     = (r_state == ST_WAIT_RESP);
  assign w_err      = (r_state == ST_ERR_RESP);
  assign w_accept_f = w_idle && w_grant[0];
  assign w_accept_l = w_idle && w_grant[1];
  assign w_cnt_next = r_cnt + 1'b1;

  assign w_owner_res_ready = (r_owner == OWNER_LSU) ? i_l_res_ready : i_f_res_ready;
  assign w_res_valid       = (w_wait && i_m_res_valid) || w_err;
  assign w_res_data        = w_wait ? i_m_data : '0;

  // Route the memory response (or the error response) to the owner only
  always_comb begin
    o_f_ready     = w_accept_f;
    o_l_ready     = w_accept_l;
    o_f_res_valid = w_res_valid && (r_owner == OWNER_FETCH);
    o_l_res_valid = w_res_valid && (r_owner == OWNER_LSU);
    o_f_data      = (r_owner == OWNER_FETCH) ? w_res_data : '0;
    o_l_data      = (r_owner == OWNER_LSU)   ? w_res_data : '0;
    o_f_err       = w_err && (r_owner == OWNER_FETCH);
    o_l_err       = w_err && (r_owner == OWNER_LSU);
    o_m_res_ready = (w_wait && w_owner_res_ready) || w_err;
    o_m_valid     = (r_state == ST_ISSUE);
    o_m_addr      = r_m_addr;
    o_m_cmd       = r_m_cmd;
    o_m_data      = r_m_data;
    o_timeout     = r_timeout;
  end

  // Transaction FSM: accept, issue to memory, await response or time out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_FETCH;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_m_addr     <= '0;
      r_m_cmd      <= '0;
      r_m_data     <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= OWNER_FETCH;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept_l) begin
            r_state      <= ST_ISSUE;
            r_owner      <= OWNER_LSU;
            r_m_addr     <= i_l_addr;
            r_m_cmd      <= i_l_cmd;
            r_m_data     <= i_l_data;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= OWNER_LSU;
`endif
          end else if (w_accept_f) begin
            r_state      <= ST_ISSUE;
            r_owner      <= OWNER_FETCH;
            r_m_addr     <= i_f_addr;
            r_m_cmd      <= `MEM_CMD_READ;
            r_m_data     <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= OWNER_FETCH;
`endif
          end
        end
        ST_ISSUE: begin
          if (i_m_ready) begin
            r_state <= ST_WAIT_RESP;
            r_cnt   <= '0;
          end
        end
        ST_WAIT_RESP: begin
          // A response present this cycle always beats the timeout
          if (i_m_res_valid) begin
            if (w_owner_res_ready) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == c_resp_timeout) begin
              r_state   <= ST_ERR_RESP;
              r_timeout <= 1'b1;
            end
          end
        end
        ST_ERR_RESP: begin
          if (w_owner_res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed, scoreboard-based self-checking bench for
//               mem_arbiter (RESP_TIMEOUT = 4). Expectations for tie
//               arbitration follow the MEM_ARB_RR_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_CMD_WIDTH
`define MEM_CMD_WIDTH 2
`endif
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 2'd0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 2'd1
`endif

module tb_mem_arbiter;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      f_valid, l_valid, f_res_ready, l_res_ready;
  logic                      m_ready, m_res_valid;
  logic [`ADDRESS_WIDTH-1:0] f_addr, l_addr;
  logic [`MEM_CMD_WIDTH-1:0] l_cmd;
  logic [`DATA_WIDTH-1:0]    l_data, m_data;
  logic                      o_f_ready, o_f_res_valid, o_f_err;
  logic                      o_l_ready, o_l_res_valid, o_l_err;
  logic                      o_m_valid, o_m_res_ready, o_timeout;
  logic [`DATA_WIDTH-1:0]    o_f_data, o_l_data, o_m_data;
  logic [`ADDRESS_WIDTH-1:0] o_m_addr;
  logic [`MEM_CMD_WIDTH-1:0] o_m_cmd;

  typedef struct {
    bit                   lsu;
    logic [`DATA_WIDTH-1:0] data;
    logic                 err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RESP_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_f_valid     (f_valid),
    .i_f_addr      (f_addr),
    .o_f_ready     (o_f_ready),
    .o_f_res_valid (o_f_res_valid),
    .o_f_data      (o_f_data),
    .o_f_err       (o_f_err),
    .i_f_res_ready (f_res_ready),
    .i_l_valid     (l_valid),
    .i_l_addr      (l_addr),
    .i_l_cmd       (l_cmd),
    .i_l_data      (l_data),
    .o_l_ready     (o_l_ready),
    .o_l_res_valid (o_l_res_valid),
    .o_l_data      (o_l_data),
    .o_l_err       (o_l_err),
    .i_l_res_ready (l_res_ready),
    .o_m_valid     (o_m_valid),
    .o_m_addr      (o_m_addr),
    .o_m_cmd       (o_m_cmd),
    .o_m_data      (o_m_data),
    .i_m_ready     (m_ready),
    .i_m_res_valid (m_res_valid),
    .i_m_data      (m_data),
    .o_m_res_ready (o_m_res_ready),
    .o_timeout     (o_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic accept(input bit lsu, input logic [31:0] addr,
                        input logic [1:0] cmd, input logic [31:0] wdata);
    if (lsu) begin
      l_valid = 1'b1; l_addr = addr; l_cmd = cmd; l_data = wdata;
    end else begin
      f_valid = 1'b1; f_addr = addr;
    end
    #1;
    chk("accept_ready", lsu ? o_l_ready : o_f_ready, 1'b1);
    tick();
    f_valid = 1'b0;
    l_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [1:0] cmd,
                       input logic [31:0] wdata, input int mwait);
    for (int i = 0; i < mwait; i++) begin
      m_ready = 1'b0;
      #1;
      chk("issue_hold_valid", o_m_valid, 1'b1);
      chk("issue_hold_addr", o_m_addr, addr);
      chk("issue_hold_cmd", o_m_cmd, cmd);
      chk("issue_hold_data", o_m_data, wdata);
      chk("issue_no_ready", {o_f_ready, o_l_ready}, 2'b00);
      tick();
    end
    m_ready = 1'b1;
    #1;
    chk("issue_valid", o_m_valid, 1'b1);
    chk("issue_addr", o_m_addr, addr);
    chk("issue_cmd", o_m_cmd, cmd);
    chk("issue_data", o_m_data, wdata);
    tick();
    m_ready = 1'b0;
  endtask

  task automatic respond(input bit lsu, input logic [31:0] rdata,
                         input int rwait, input int rrwait);
    exp_t e;
    for (int i = 0; i < rwait; i++) begin
      #1;
      chk("no_early_res", lsu ? o_l_res_valid : o_f_res_valid, 1'b0);
      tick();
    end
    m_res_valid = 1'b1;
    m_data      = rdata;
    sb.push_back('{lsu, rdata, 1'b0});
    for (int i = 0; i < rrwait; i++) begin
      #1;
      chk("res_stall_mrr", o_m_res_ready, 1'b0);
      chk("res_stall_valid", lsu ? o_l_res_valid : o_f_res_valid, 1'b1);
      tick();
    end
    if (lsu) l_res_ready = 1'b1; else f_res_ready = 1'b1;
    #1;
    e = sb.pop_front();
    chk("res_owner_valid", e.lsu ? o_l_res_valid : o_f_res_valid, 1'b1);
    chk("res_other_valid", e.lsu ? o_f_res_valid : o_l_res_valid, 1'b0);
    chk("res_mrr", o_m_res_ready, 1'b1);
    chk("res_data", e.lsu ? o_l_data : o_f_data, e.data);
    chk("res_err", e.lsu ? o_l_err : o_f_err, e.err);
    tick();
    m_res_valid = 1'b0;
    m_data      = '0;
    f_res_ready = 1'b0;
    l_res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_lsu;
    reset = 1'b0;
    f_valid = 1'b1; l_valid = 1'b1;
    f_addr = '0; l_addr = '0; l_cmd = '0; l_data = '0;
    f_res_ready = 1'b0; l_res_ready = 1'b0;
    m_ready = 1'b0; m_res_valid = 1'b0; m_data = '0;

    // Reset state, requests held valid must not be accepted
    #3;
    chk("rst_f_ready", o_f_ready, 1'b0);
    chk("rst_l_ready", o_l_ready, 1'b0);
    chk("rst_m_valid", o_m_valid, 1'b0);
    chk("rst_m_fields", {o_m_addr, o_m_cmd}, '0);
    chk("rst_m_data", o_m_data, '0);
    chk("rst_res", {o_f_res_valid, o_l_res_valid, o_f_err, o_l_err, o_m_res_ready}, '0);
    chk("rst_timeout", o_timeout, 1'b0);
    tick();
    f_valid = 1'b0; l_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Basic fetch read
    accept(1'b0, 32'h100, `MEM_CMD_READ, 32'h0);
    issue(32'h100, `MEM_CMD_READ, 32'h0, 0);
    respond(1'b0, 32'hDEADBEEF, 1, 0);
    f_valid = 1'b1;
    #1;
    chk("idle_after_fetch", o_f_ready, 1'b1);
    f_valid = 1'b0;

    // Tie arbitration over four back-to-back transactions
    do_reset();
    f_valid = 1'b1; l_valid = 1'b1;
    f_addr = 32'h300; l_addr = 32'h400; l_cmd = `MEM_CMD_READ; l_data = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      #1;
      chk("tie_l_ready", o_l_ready, exp_lsu);
      chk("tie_f_ready", o_f_ready, !exp_lsu);
      tick();
      issue(exp_lsu ? 32'h400 : 32'h300, `MEM_CMD_READ, 32'h0, 0);
      respond(exp_lsu, 32'hA0 + i, 0, 0);
    end
    f_valid = 1'b0; l_valid = 1'b0;

    // LSU write with memory stalling; write response forwards memory data
    accept(1'b1, 32'h200, `MEM_CMD_WRITE, 32'h55);
    issue(32'h200, `MEM_CMD_WRITE, 32'h55, 5);
    respond(1'b1, 32'h1234, 0, 0);

    // Fetch consumer stalls the response for three cycles
    accept(1'b0, 32'h140, `MEM_CMD_READ, 32'h0);
    issue(32'h140, `MEM_CMD_READ, 32'h0, 0);
    respond(1'b0, 32'hCAFE0001, 0, 3);

    // Response in the cycle the counter would reach the limit wins
    accept(1'b1, 32'h600, `MEM_CMD_READ, 32'h0);
    issue(32'h600, `MEM_CMD_READ, 32'h0, 0);
    respond(1'b1, 32'h0BADF00D, 3, 0);
    #1;
    chk("late_win_no_timeout", o_timeout, 1'b0);

    // Timeout with no memory response
    accept(1'b1, 32'h700, `MEM_CMD_READ, 32'h0);
    issue(32'h700, `MEM_CMD_READ, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_no_res", o_l_res_valid, 1'b0);
      chk("to_wait_flag", o_timeout, 1'b0);
      tick();
    end
    sb.push_back('{1'b1, 32'h0, 1'b1});
    #1;
    chk("to_err_valid", o_l_res_valid, 1'b1);
    chk("to_err_flag", o_timeout, 1'b1);
    chk("to_err_mrr", o_m_res_ready, 1'b1);
    chk("to_err_f_valid", o_f_res_valid, 1'b0);
    tick();
    l_res_ready = 1'b1;
    #1;
    begin
      exp_t e;
      e = sb.pop_front();
      chk("to_err_hold_valid", o_l_res_valid, 1'b1);
      chk("to_err_data", o_l_data, e.data);
      chk("to_err_err", o_l_err, e.err);
    end
    tick();
    l_res_ready = 1'b0;

    // Sticky timeout survives a later good transaction
    accept(1'b0, 32'h180, `MEM_CMD_READ, 32'h0);
    issue(32'h180, `MEM_CMD_READ, 32'h0, 0);
    respond(1'b0, 32'h11112222, 0, 0);
    #1;
    chk("timeout_sticky", o_timeout, 1'b1);

    // Reset in the middle of WAIT_RESP
    accept(1'b0, 32'h500, `MEM_CMD_READ, 32'h0);
    issue(32'h500, `MEM_CMD_READ, 32'h0, 0);
    m_res_valid = 1'b1; m_data = 32'h77; f_res_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_f_res", o_f_res_valid, 1'b0);
    chk("mid_rst_mrr", o_m_res_ready, 1'b0);
    chk("mid_rst_m_valid", o_m_valid, 1'b0);
    chk("mid_rst_m_addr", o_m_addr, '0);
    chk("mid_rst_timeout", o_timeout, 1'b0);
    tick();
    m_res_valid = 1'b0; m_data = '0; f_res_ready = 1'b0;
    reset = 1'b1;
    tick();
    accept(1'b0, 32'h580, `MEM_CMD_READ, 32'h0);
    issue(32'h580, `MEM_CMD_READ, 32'h0, 0);
    respond(1'b0, 32'h5A5A5A5A, 1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
